// File: rtl/operand_fetch_stage.sv
// operand_fetch_stage
//   ID stage between instruction fetch and execute. Decodes the incoming
//   instruction, drives the register-file read addresses, bypasses the
//   same-cycle write-back into the operands, sign-extends the immediate and
//   registers everything into the ID/EX pipeline register. A load followed
//   by a dependent instruction inserts one bubble and back-pressures fetch.
//
// Ports
//   clk, reset            rising-edge clock, synchronous active-high reset
//   instr, instrValid     instruction from fetch
//   instrReady            stage accepts instr this cycle
//   rfReadReg1/2          register file read addresses (rs / rt)
//   rfReadData1/2         register file read data
//   wbRegWrite/WriteReg/WriteData   write-back port, used for bypass
//   exStall               execute holds; ID/EX frozen
//   ex*                   ID/EX register contents
//   stallCount            saturating count of inserted bubbles
module operand_fetch_stage #(
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [31:0]            instr,
    input  logic                   instrValid,
    output logic                   instrReady,
    output logic [4:0]             rfReadReg1,
    output logic [4:0]             rfReadReg2,
    input  logic [31:0]            rfReadData1,
    input  logic [31:0]            rfReadData2,
    input  logic                   wbRegWrite,
    input  logic [4:0]             wbWriteReg,
    input  logic [31:0]            wbWriteData,
    input  logic                   exStall,
    output logic                   exValid,
    output logic [31:0]            exOpA,
    output logic [31:0]            exOpB,
    output logic [31:0]            exImm,
    output logic [4:0]             exRs,
    output logic [4:0]             exRt,
    output logic [4:0]             exWriteReg,
    output logic                   exRegWrite,
    output logic                   exMemRead,
    output logic                   exMemWrite,
    output logic                   exBranch,
    output logic                   exAluSrcImm,
    output logic                   exIllegal,
    output logic [STALL_CNT_W-1:0] stallCount
);

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;

    localparam logic [STALL_CNT_W-1:0] CNT_ONE = {{(STALL_CNT_W-1){1'b0}}, 1'b1};

    logic [5:0]  opcode;
    logic [4:0]  rs, rt, rd;
    logic [31:0] op_a, op_b, imm_ext;

    logic       dec_reg_write, dec_mem_read, dec_mem_write;
    logic       dec_branch, dec_alu_src_imm, dec_illegal, uses_rt;
    logic [4:0] dec_write_reg;
    logic       hazard;

    assign opcode = instr[31:26];
    assign rs     = instr[25:21];
    assign rt     = instr[20:16];
    assign rd     = instr[15:11];

    assign rfReadReg1 = rs;
    assign rfReadReg2 = rt;

    // The register file writes on the clock edge, so a write-back to a
    // source register this cycle is not yet visible on readData.
    assign op_a = (wbRegWrite && (wbWriteReg == rs)) ? wbWriteData : rfReadData1;
    assign op_b = (wbRegWrite && (wbWriteReg == rt)) ? wbWriteData : rfReadData2;

    assign imm_ext = {{16{instr[15]}}, instr[15:0]};

    always_comb begin
        dec_reg_write   = 1'b0;
        dec_mem_read    = 1'b0;
        dec_mem_write   = 1'b0;
        dec_branch      = 1'b0;
        dec_alu_src_imm = 1'b0;
        dec_illegal     = 1'b0;
        dec_write_reg   = 5'd0;
        uses_rt         = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                dec_reg_write = 1'b1;
                dec_write_reg = rd;
                uses_rt       = 1'b1;
            end
            OP_LW: begin
                dec_reg_write   = 1'b1;
                dec_mem_read    = 1'b1;
                dec_alu_src_imm = 1'b1;
                dec_write_reg   = rt;
            end
            OP_SW: begin
                dec_mem_write   = 1'b1;
                dec_alu_src_imm = 1'b1;
                uses_rt         = 1'b1;
            end
            OP_BEQ: begin
                dec_branch = 1'b1;
                uses_rt    = 1'b1;
            end
            OP_ADDI: begin
                dec_reg_write   = 1'b1;
                dec_alu_src_imm = 1'b1;
                dec_write_reg   = rt;
            end
            default: dec_illegal = 1'b1;
        endcase
    end

    // Load in EX whose destination is a source here: the loaded value is not
    // available for forwarding until one cycle later.
    assign hazard = exValid && exMemRead && instrValid && (exWriteReg != 5'd0) &&
                    ((exWriteReg == rs) || (uses_rt && (exWriteReg == rt)));

    assign instrReady = !exStall && !hazard;

    always_ff @(posedge clk) begin
        if (reset) begin
            exValid     <= 1'b0;
            exOpA       <= '0;
            exOpB       <= '0;
            exImm       <= '0;
            exRs        <= '0;
            exRt        <= '0;
            exWriteReg  <= '0;
            exRegWrite  <= 1'b0;
            exMemRead   <= 1'b0;
            exMemWrite  <= 1'b0;
            exBranch    <= 1'b0;
            exAluSrcImm <= 1'b0;
            exIllegal   <= 1'b0;
            stallCount  <= '0;
        end else if (!exStall) begin
            if (hazard) begin
                // Bubble: data fields keep their old values.
                exValid     <= 1'b0;
                exRegWrite  <= 1'b0;
                exMemRead   <= 1'b0;
                exMemWrite  <= 1'b0;
                exBranch    <= 1'b0;
                exAluSrcImm <= 1'b0;
                exIllegal   <= 1'b0;
                if (stallCount != '1)
                    stallCount <= stallCount + CNT_ONE;
            end else begin
                exValid     <= instrValid;
                exOpA       <= op_a;
                exOpB       <= op_b;
                exImm       <= imm_ext;
                exRs        <= rs;
                exRt        <= rt;
                exWriteReg  <= dec_write_reg;
                exRegWrite  <= instrValid && dec_reg_write;
                exMemRead   <= instrValid && dec_mem_read;
                exMemWrite  <= instrValid && dec_mem_write;
                exBranch    <= instrValid && dec_branch;
                exAluSrcImm <= instrValid && dec_alu_src_imm;
                exIllegal   <= instrValid && dec_illegal;
            end
        end
    end

endmodule

// File: tb/tb_operand_fetch_stage.sv
// Testbench for operand_fetch_stage: directed test-plan steps followed by a
// randomized phase, all checked against a cycle-level reference model and a
// behavioural register file (reg[i]=i at power-up, writes on the edge).
module tb_operand_fetch_stage;

    localparam int W = 4;  // small counter width so saturation is reachable

    typedef struct packed {
        logic        v;
        logic [31:0] a, b, imm;
        logic [4:0]  rs, rt, wr;
        logic        rw, mr, mw, br, ai, il;
    } ex_t;

    logic          clk = 1'b0;
    logic          reset;
    logic [31:0]   instr;
    logic          instrValid;
    logic          instrReady;
    logic [4:0]    rfReadReg1, rfReadReg2;
    logic [31:0]   rfReadData1, rfReadData2;
    logic          wbRegWrite;
    logic [4:0]    wbWriteReg;
    logic [31:0]   wbWriteData;
    logic          exStall;
    logic          exValid;
    logic [31:0]   exOpA, exOpB, exImm;
    logic [4:0]    exRs, exRt, exWriteReg;
    logic          exRegWrite, exMemRead, exMemWrite, exBranch, exAluSrcImm, exIllegal;
    logic [W-1:0]  stallCount;

    logic [31:0] rf [32];
    assign rfReadData1 = rf[rfReadReg1];
    assign rfReadData2 = rf[rfReadReg2];

    int checks = 0;
    int errors = 0;

    ex_t      m;
    int       cnt;
    logic     exp_ready;
    bit       started = 0;

    always #5 clk = ~clk;

    operand_fetch_stage #(.STALL_CNT_W(W)) dut (
        .clk(clk), .reset(reset), .instr(instr), .instrValid(instrValid),
        .instrReady(instrReady), .rfReadReg1(rfReadReg1), .rfReadReg2(rfReadReg2),
        .rfReadData1(rfReadData1), .rfReadData2(rfReadData2),
        .wbRegWrite(wbRegWrite), .wbWriteReg(wbWriteReg), .wbWriteData(wbWriteData),
        .exStall(exStall), .exValid(exValid), .exOpA(exOpA), .exOpB(exOpB),
        .exImm(exImm), .exRs(exRs), .exRt(exRt), .exWriteReg(exWriteReg),
        .exRegWrite(exRegWrite), .exMemRead(exMemRead), .exMemWrite(exMemWrite),
        .exBranch(exBranch), .exAluSrcImm(exAluSrcImm), .exIllegal(exIllegal),
        .stallCount(stallCount)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference semantics of one instruction, written from the opcode table.
    function automatic ex_t model_decode(input logic [31:0] ins, input logic vld,
                                         input logic [31:0] a, input logic [31:0] b);
        ex_t e;
        e = '0;
        e.v   = vld;
        e.a   = a;
        e.b   = b;
        e.imm = 32'(signed'(ins[15:0]));
        e.rs  = ins[25:21];
        e.rt  = ins[20:16];
        case (ins[31:26])
            6'h00: begin e.rw = 1; e.wr = ins[15:11]; end
            6'h23: begin e.rw = 1; e.mr = 1; e.ai = 1; e.wr = ins[20:16]; end
            6'h2B: begin e.mw = 1; e.ai = 1; end
            6'h04: e.br = 1;
            6'h08: begin e.rw = 1; e.ai = 1; e.wr = ins[20:16]; end
            default: e.il = 1;
        endcase
        if (!vld) {e.rw, e.mr, e.mw, e.br, e.ai, e.il} = '0;
        return e;
    endfunction

    task automatic check_all();
        chk("exValid", exValid, m.v);
        chk("exOpA", exOpA, m.a);
        chk("exOpB", exOpB, m.b);
        chk("exImm", exImm, m.imm);
        chk("exRs", exRs, m.rs);
        chk("exRt", exRt, m.rt);
        chk("exWriteReg", exWriteReg, m.wr);
        chk("exRegWrite", exRegWrite, m.rw);
        chk("exMemRead", exMemRead, m.mr);
        chk("exMemWrite", exMemWrite, m.mw);
        chk("exBranch", exBranch, m.br);
        chk("exAluSrcImm", exAluSrcImm, m.ai);
        if (m.v) chk("exIllegal", exIllegal, m.il);
        chk("stallCount", stallCount, cnt);
    endtask

    // One clock: check combinational outputs, predict, clock, compare.
    task automatic tick();
        ex_t n;
        int  cnt_n;
        logic [4:0] rs, rt;
        logic [31:0] a, b;
        logic urt, hz;
        #1;
        rs  = instr[25:21];
        rt  = instr[20:16];
        urt = (instr[31:26] == 6'h00) || (instr[31:26] == 6'h2B) || (instr[31:26] == 6'h04);
        hz  = m.v && m.mr && instrValid && (m.wr != 0) && ((m.wr == rs) || (urt && (m.wr == rt)));
        exp_ready = !exStall && !hz;
        chk("rfReadReg1", rfReadReg1, rs);
        chk("rfReadReg2", rfReadReg2, rt);
        if (started) chk("instrReady", instrReady, exp_ready);
        a = (wbRegWrite && wbWriteReg == rs) ? wbWriteData : rf[rs];
        b = (wbRegWrite && wbWriteReg == rt) ? wbWriteData : rf[rt];
        n = m;
        cnt_n = cnt;
        if (reset) begin
            n = '0;
            cnt_n = 0;
        end else if (exStall) begin
            n = m;
        end else if (hz) begin
            n.v = 0;
            {n.rw, n.mr, n.mw, n.br, n.ai, n.il} = '0;
            if (cnt < (1 << W) - 1) cnt_n = cnt + 1;
        end else begin
            n = model_decode(instr, instrValid, a, b);
        end
        @(posedge clk);
        #1;
        if (wbRegWrite) rf[wbWriteReg] = wbWriteData;
        m = n;
        cnt = cnt_n;
        started = 1;
        check_all();
    endtask

    task automatic drive(input logic [31:0] ins, input logic vld);
        instr = ins;
        instrValid = vld;
    endtask

    localparam logic [31:0] ADD_3_1_2  = 32'h0022_1820;
    localparam logic [31:0] ADD_7_5_1  = 32'h00A1_3820;
    localparam logic [31:0] LW_4_8_1   = 32'h8C24_0008;
    localparam logic [31:0] ADD_5_4_2  = 32'h0082_2820;
    localparam logic [31:0] ADDI_6_0_4 = 32'h2006_0004;
    localparam logic [31:0] ADDI_NEG4  = 32'h2006_FFFC;
    localparam logic [31:0] ILLEGAL    = 32'hFC00_0000;

    initial begin
        logic [5:0] ops [6];
        logic [31:0] ins;
        int cnt_before;
        ops[0] = 6'h00; ops[1] = 6'h23; ops[2] = 6'h2B;
        ops[3] = 6'h04; ops[4] = 6'h08; ops[5] = 6'h3F;
        for (int i = 0; i < 32; i++) rf[i] = i;
        m = '0;
        cnt = 0;
        reset = 1; exStall = 0; wbRegWrite = 0; wbWriteReg = 0; wbWriteData = 0;
        drive(32'h0, 1'b0);
        tick();
        tick();
        reset = 0;
        #1;
        chk("reset_ready", instrReady, 1'b1);
        chk("reset_valid", exValid, 1'b0);

        // add $3,$1,$2 with power-up register values
        drive(ADD_3_1_2, 1);
        tick();
        chk("add_valid", exValid, 1'b1);
        chk("add_opA", exOpA, 32'd1);
        chk("add_opB", exOpB, 32'd2);
        chk("add_wr", exWriteReg, 5'd3);
        chk("add_rw", exRegWrite, 1'b1);

        // bypass miss then hit on rs=5
        drive(ADD_7_5_1, 1);
        wbRegWrite = 1; wbWriteReg = 6; wbWriteData = 32'hDEADBEEF;
        tick();
        chk("bypass_miss", exOpA, 32'd5);
        wbWriteReg = 5;
        tick();
        chk("bypass_hit", exOpA, 32'hDEADBEEF);
        wbRegWrite = 0;

        // load-use: lw $4 then add $5,$4,$2
        drive(LW_4_8_1, 1);
        tick();
        drive(ADD_5_4_2, 1);
        #1;
        chk("lu_ready", instrReady, 1'b0);
        tick();
        chk("lu_bubble", exValid, 1'b0);
        chk("lu_count", stallCount, 1);
        tick();
        chk("lu_accept_valid", exValid, 1'b1);
        chk("lu_accept_rs", exRs, 5'd4);

        // no hazard: lw $4 then addi $6,$0,4
        drive(LW_4_8_1, 1);
        tick();
        drive(ADDI_6_0_4, 1);
        #1;
        chk("nohz_ready", instrReady, 1'b1);
        tick();
        chk("nohz_valid", exValid, 1'b1);
        chk("nohz_count", stallCount, 1);

        // exStall hold for 3 cycles with varying instr
        exStall = 1;
        for (int i = 0; i < 3; i++) begin
            drive($urandom, 1);
            #1;
            chk("stall_ready", instrReady, 1'b0);
            tick();
            chk("stall_hold_wr", exWriteReg, 5'd6);
            chk("stall_hold_cnt", stallCount, 1);
        end
        exStall = 0;

        // illegal opcode and negative immediate
        drive(ILLEGAL, 1);
        tick();
        chk("ill_flag", exIllegal, 1'b1);
        chk("ill_rw", exRegWrite, 1'b0);
        chk("ill_mw", exMemWrite, 1'b0);
        drive(ADDI_NEG4, 1);
        tick();
        chk("imm_sext", exImm, 32'hFFFF_FFFC);

        // reset during a hazard cycle
        drive(LW_4_8_1, 1);
        tick();
        drive(ADD_5_4_2, 1);
        #1;
        chk("rst_hz_ready", instrReady, 1'b0);
        reset = 1;
        tick();
        reset = 0;
        chk("rst_hz_valid", exValid, 1'b0);
        chk("rst_hz_cnt", stallCount, 0);
        #1;
        chk("rst_hz_ready_after", instrReady, 1'b1);

        // counter saturation: 16 load-use pairs
        for (int i = 0; i < 16; i++) begin
            drive(LW_4_8_1, 1);
            tick();
            drive(ADD_5_4_2, 1);
            tick();
            tick();
        end
        chk("sat_count", stallCount, (1 << W) - 1);

        // randomized phase; fetch holds instr while not ready
        drive(32'h0, 0);
        for (int i = 0; i < 400; i++) begin
            if (started && !exp_ready && instrValid) begin
                // hold instr
            end else begin
                ins = {ops[$urandom_range(0, 5)], 5'($urandom_range(0, 7)),
                       5'($urandom_range(0, 7)), 16'($urandom)};
                drive(ins, $urandom_range(0, 9) < 8);
            end
            exStall     = $urandom_range(0, 9) < 2;
            reset       = $urandom_range(0, 99) < 2;
            wbRegWrite  = $urandom_range(0, 1);
            wbWriteReg  = 5'($urandom_range(0, 7));
            wbWriteData = $urandom;
            cnt_before  = cnt;
            tick();
            if (cnt != cnt_before && !reset) chk("rand_bubble_valid", exValid, 1'b0);
        end
        reset = 0;
        exStall = 0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
